// File: rtl/dot_matrix_pkg.sv
// Shared definitions for the dot-matrix display path (frame buffer and row
// scanner): matrix geometry, row/frame types and the commit/swap state type.
// No ports.
package dot_matrix_pkg;

   localparam int DOT_ROWS = 8;
   localparam int DOT_COLS = 8;
   localparam int DOT_RW   = $clog2(DOT_ROWS);

   typedef logic [DOT_COLS-1:0]  dot_row_t;
   typedef dot_row_t [DOT_ROWS-1:0] frame_t;

   typedef enum logic {
      ST_OPEN    = 1'b0,
      ST_PENDING = 1'b1
   } fb_state_t;

endpackage

// File: rtl/dot_matrix_frame_buffer_if.sv
// Producer/scanner bus of the dot-matrix frame buffer.
//   master : pattern producer + row scanner (drives wr_* and scan_row/start)
//   slave  : frame buffer (returns wr_ready, scan_col, swap status)
interface dot_matrix_frame_buffer_if
   import dot_matrix_pkg::*;
#(
   parameter int ROWS = DOT_ROWS,
   parameter int COLS = DOT_COLS,
   parameter int RW   = $clog2(ROWS)
);

   logic            wr_valid;
   logic            wr_ready;
   logic [RW-1:0]   wr_row;
   logic [COLS-1:0] wr_data;
   logic            wr_last;
   logic [RW-1:0]   scan_row;
   logic            scan_frame_start;
   logic [COLS-1:0] scan_col;
   logic            swap_pending;
   logic [7:0]      swap_count;

   modport master (
      output wr_valid, wr_row, wr_data, wr_last, scan_row, scan_frame_start,
      input  wr_ready, scan_col, swap_pending, swap_count
   );

   modport slave (
      input  wr_valid, wr_row, wr_data, wr_last, scan_row, scan_frame_start,
      output wr_ready, scan_col, swap_pending, swap_count
   );

endinterface

// File: rtl/dot_frame_bank.sv
// One ROWS x COLS bank of the frame store.
//   clk, rst_n          : clock, asynchronous active-low clear of all rows
//   wr_en/wr_row/wr_data: single-row write; rows >= ROWS are ignored
//   load_en/load_data   : whole-frame load, takes priority over a row write
//   rd_row/rd_data      : asynchronous row read; rows >= ROWS read as 0
//   frame               : full bank contents (source for a bulk load)
module dot_frame_bank
   import dot_matrix_pkg::*;
#(
   parameter int ROWS = DOT_ROWS,
   parameter int COLS = DOT_COLS,
   parameter int RW   = $clog2(ROWS)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      wr_en,
   input  logic [RW-1:0]             wr_row,
   input  logic [COLS-1:0]           wr_data,
   input  logic                      load_en,
   input  logic [ROWS-1:0][COLS-1:0] load_data,
   input  logic [RW-1:0]             rd_row,
   output logic [COLS-1:0]           rd_data,
   output logic [ROWS-1:0][COLS-1:0] frame
);

   logic [ROWS-1:0][COLS-1:0] frame_q;
   logic [ROWS-1:0][COLS-1:0] frame_d;

   // Row decode by loop so an out-of-range index simply matches nothing.
   always_comb begin
      frame_d = frame_q;
      if (load_en) begin
         frame_d = load_data;
      end else if (wr_en) begin
         for (int r = 0; r < ROWS; r++) begin
            if (wr_row == RW'(r)) frame_d[r] = wr_data;
         end
      end
   end

   always_comb begin
      rd_data = '0;
      for (int r = 0; r < ROWS; r++) begin
         if (rd_row == RW'(r)) rd_data = frame_q[r];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) frame_q <= '0;
      else        frame_q <= frame_d;
   end

   assign frame = frame_q;

endmodule

// File: rtl/dot_matrix_frame_buffer.sv
// Double-buffered dot-matrix frame store. The producer fills the back bank and
// commits with wr_last; the banks swap on the next scan_frame_start so the
// scanner never sees a half-written frame.
//   div_clk : scan-domain clock
//   rst     : asynchronous active-low reset
//   bus     : slave side of dot_matrix_frame_buffer_if (write handshake,
//             scan row request/data, swap status)
// Build option: DOT_FB_COPY_ON_SWAP_EN copies the new front frame into the new
// back bank on every swap, so a producer may rewrite only changed rows.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_OPEN    | back bank accepts row writes (wr_ready=1)
// ST_PENDING | frame committed, waiting for scan_frame_start to swap
module dot_matrix_frame_buffer
   import dot_matrix_pkg::*;
#(
   parameter int ROWS = DOT_ROWS,
   parameter int COLS = DOT_COLS,
   parameter int RW   = $clog2(ROWS)
) (
   input logic                     div_clk,
   input logic                     rst,
   dot_matrix_frame_buffer_if.slave bus
);

   fb_state_t       state_q, state_d;
   logic            front_q, front_d;
   logic [7:0]      swap_count_q, swap_count_d;
   logic [COLS-1:0] scan_col_q, scan_col_d;

   logic accept;
   logic swap;
   logic copy_load;

   logic [COLS-1:0]           bank_rd    [2];
   logic [ROWS-1:0][COLS-1:0] bank_frame [2];

   // A commit only arms the swap; a frame start in the same cycle is seen
   // while still ST_OPEN and therefore has no effect.
   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      swap    = 1'b0;
      case (state_q)
         ST_OPEN: begin
            accept = bus.wr_valid;
            if (bus.wr_valid && bus.wr_last) state_d = ST_PENDING;
         end
         ST_PENDING: begin
            if (bus.scan_frame_start) begin
               swap    = 1'b1;
               state_d = ST_OPEN;
            end
         end
         default: state_d = ST_OPEN;
      endcase
   end

`ifdef DOT_FB_COPY_ON_SWAP_EN
   assign copy_load = swap;
`else
   assign copy_load = 1'b0;
`endif

   // The bank that is front before the swap becomes back after it, so that is
   // the one loaded with the other bank's (new front) contents.
   for (genvar b = 0; b < 2; b++) begin : g_bank
      dot_frame_bank #(
         .ROWS (ROWS),
         .COLS (COLS),
         .RW   (RW)
      ) u_bank (
         .clk       (div_clk),
         .rst_n     (rst),
         .wr_en     (accept && (front_q != 1'(b))),
         .wr_row    (bus.wr_row),
         .wr_data   (bus.wr_data),
         .load_en   (copy_load && (front_q == 1'(b))),
         .load_data (bank_frame[1-b]),
         .rd_row    (bus.scan_row),
         .rd_data   (bank_rd[b]),
         .frame     (bank_frame[b])
      );
   end

   always_comb begin
      front_d      = front_q ^ swap;
      swap_count_d = swap_count_q + 8'(swap);
      scan_col_d   = bank_rd[front_q];
   end

   always_ff @(posedge div_clk or negedge rst) begin
      if (!rst) begin
         state_q      <= ST_OPEN;
         front_q      <= 1'b0;
         swap_count_q <= '0;
         scan_col_q   <= '0;
      end else begin
         state_q      <= state_d;
         front_q      <= front_d;
         swap_count_q <= swap_count_d;
         scan_col_q   <= scan_col_d;
      end
   end

   assign bus.swap_pending = (state_q == ST_PENDING);
   assign bus.wr_ready     = (state_q != ST_PENDING);
   assign bus.swap_count   = swap_count_q;
   assign bus.scan_col     = scan_col_q;

endmodule
